hit_judge: RTL
==============

// Module: hit_judge
// PURPOSE
//  Produces the collision and die inputs that the game-flow FSM consumes, and takes back
//  its game_state/game_en/game_reset. Raw per-pixel overlap strobes from the renderer
//  (enemy bullet vs player, player bullet vs boss) are condensed into at most one event
//  per frame. The block tracks boss HP, applies bullet and bomb damage, and gates player
//  hits by the FSM's invulnerable states.
// PARAMETERS
//  BOSS_HP     100  boss HP loaded on reset/game_reset; must be < 2**HP_W
//  HP_W        8    boss_hp width
//  BULLET_DMG  1    HP removed per frame with a boss hit
//  BOMB_DMG    10   extra HP removed per frame while game_state==BOMB
// PORTS
//  clk           in   1     system clock
//  hard_reset_n  in   1     asynchronous, active-low reset
//  game_reset    in   1     1-cycle synchronous clear from game FSM
//  game_en       in   1     game running (from game FSM)
//  game_state    in   4     FSM state: INITIAL 0000, START 0001, PLAY 0010, COLLISION 1010,
//                           BOMB 0110, SUCCESS 1000, GAMEOVER 1001
//  frame_tick    in   1     1-cycle strobe, once per video frame
//  player_hit    in   1     raw overlap, enemy bullet/boss vs player; any length
//  boss_hit      in   1     raw overlap, player bullet vs boss; any length
//  collision     out  1     1-cycle pulse: player lost a life this frame
//  die           out  1     level: boss defeated
//  boss_hp       out  HP_W  current boss HP, for HUD
// BEHAVIOUR
//  - Reset (hard_reset_n=0, async): boss_hp=BOSS_HP, collision=0, die=0, both flags clear,
//    judge state IDLE. Reset applies immediately, including mid-frame.
//  - Sticky flags p_flag and b_flag: each sets on any cycle its hit input is 1. Both clear
//    on the cycle after frame_tick. A hit that arrives in the same cycle as frame_tick
//    counts toward the closing frame.
//  - Judge FSM:
//    - IDLE -> ARMED when game_en=1.
//    - ARMED -> DEAD on the edge that makes boss_hp 0.
//    - ARMED -> IDLE when game_en=0.
//    - DEAD -> IDLE only on game_reset.
//    - In IDLE, no damage is applied and no collision is produced.
//  - Evaluation happens on frame_tick in ARMED. Results are registered: collision, die and
//    boss_hp change on the edge after the frame_tick cycle (latency 1).
//  - Damage:
//    - dmg = (b_flag && state in {PLAY,COLLISION,BOMB} ? BULLET_DMG : 0)
//      + (game_state==BOMB ? BOMB_DMG : 0).
//    - Compute in HP_W+1 bits. boss_hp = (dmg >= boss_hp) ? 0 : boss_hp-dmg. Never wraps.
//  - collision = 1 for exactly one cycle iff p_flag && game_state==PLAY && new boss_hp != 0.
//    Player hits in COLLISION, BOMB or any other state are discarded. A hit held for a whole
//    frame still yields one pulse.
//  - Same frame boss kill + player hit: die=1, collision=0 (player-favoured).
//  - die asserts on entry to DEAD. It holds through SUCCESS and later frame_ticks.
//    boss_hp stays 0.
//  - game_reset (sync, any state): boss_hp=BOSS_HP, die=0, collision=0, flags clear, IDLE.
//    game_reset wins over a frame_tick or hit in the same cycle.
//  - Any game_state code not listed: treated as not PLAY/COLLISION/BOMB.
// STRUCTURE
//  - Shared package stg_pkg: game_state codes (ST_INITIAL..ST_GAMEOVER, 4-bit) and judge
//    state codes (J_IDLE, J_ARMED, J_DEAD). The game FSM uses the same codes.
//  - Sub-module frame_sticky (clk, hard_reset_n, clr, in, tick -> flag), instantiated twice
//    for p_flag and b_flag.
//  - Top level holds the judge FSM, the saturating HP datapath and the output registers.
// TESTING (BOSS_HP=5, BULLET_DMG=1, BOMB_DMG=2, HP_W=8)
//  1. Pull hard_reset_n low mid-frame with boss_hp=3 -> boss_hp=5, collision=0, die=0
//     at once, without waiting for a clk edge.
//  2. PLAY, game_en=1, player_hit high 300 cycles, then frame_tick -> one collision pulse
//     1 cycle after tick; no pulse on the next tick.
//  3. game_state=COLLISION, player_hit and boss_hit in one frame -> collision stays 0;
//     boss_hp 5->4.
//  4. game_state=BOMB, no hits, 3 ticks -> boss_hp 3, 1, 0; die=1 after 3rd tick;
//     4th tick keeps boss_hp=0, die=1.
//  5. boss_hp=1, PLAY, boss_hit and player_hit in same frame -> die=1, collision=0.
//  6. While DEAD, pulse game_reset coincident with frame_tick and boss_hit -> die=0,
//     boss_hp=5, no collision. Then game_en=1 re-arms.

Source files
------------

// File: rtl/stg_pkg.sv
// Shared game-state and judge-state codes for the shooter game-flow logic.
// The game FSM and hit_judge both import these so the encodings cannot drift apart.
package stg_pkg;

  localparam logic [3:0] ST_INITIAL   = 4'b0000;
  localparam logic [3:0] ST_START     = 4'b0001;
  localparam logic [3:0] ST_PLAY      = 4'b0010;
  localparam logic [3:0] ST_COLLISION = 4'b1010;
  localparam logic [3:0] ST_BOMB      = 4'b0110;
  localparam logic [3:0] ST_SUCCESS   = 4'b1000;
  localparam logic [3:0] ST_GAMEOVER  = 4'b1001;

  typedef enum logic [1:0] {
    J_IDLE  = 2'd0,
    J_ARMED = 2'd1,
    J_DEAD  = 2'd2
  } judge_t;

  // Boss can take bullet damage only while the player is actively fighting.
  function automatic logic boss_vulnerable(input logic [3:0] gs);
    return (gs == ST_PLAY) || (gs == ST_COLLISION) || (gs == ST_BOMB);
  endfunction

endpackage

// File: rtl/frame_sticky.sv
// Per-frame sticky hit flag: remembers any overlap strobe seen during the current frame.
// The live input is OR-ed in so a hit on the frame_tick cycle counts toward the closing frame.
module frame_sticky (
  input  logic clk,
  input  logic hard_reset_n,
  input  logic clr,
  input  logic in,
  input  logic tick,
  output logic flag
);

  logic flag_q;

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      flag_q <= 1'b0;
    end else if (clr || tick) begin
      flag_q <= 1'b0;
    end else if (in) begin
      flag_q <= 1'b1;
    end
  end

  assign flag = flag_q | in;

endmodule

// File: rtl/hit_judge.sv
// Condenses raw overlap strobes into per-frame collision/die events and tracks boss HP.
//
// state   | meaning
// J_IDLE  | game not running; hits and damage ignored
// J_ARMED | game running; frame_tick evaluates the frame's hits
// J_DEAD  | boss HP reached 0; die held until game_reset
module hit_judge
  import stg_pkg::*;
#(
  parameter int BOSS_HP    = 100,
  parameter int HP_W       = 8,
  parameter int BULLET_DMG = 1,
  parameter int BOMB_DMG   = 10
) (
  input  logic            clk,
  input  logic            hard_reset_n,
  input  logic            game_reset,
  input  logic            game_en,
  input  logic [3:0]      game_state,
  input  logic            frame_tick,
  input  logic            player_hit,
  input  logic            boss_hit,
  output logic            collision,
  output logic            die,
  output logic [HP_W-1:0] boss_hp
);

  localparam logic [HP_W-1:0] HP_INIT  = HP_W'(BOSS_HP);
  localparam logic [HP_W:0]   BULLET_W = (HP_W+1)'(BULLET_DMG);
  localparam logic [HP_W:0]   BOMB_W   = (HP_W+1)'(BOMB_DMG);

  logic            p_flag;
  logic            b_flag;
  judge_t          state_q, state_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic            coll_q, coll_d;
  logic            die_q, die_d;
  logic [HP_W:0]   dmg;
  logic [HP_W-1:0] new_hp;

  frame_sticky u_p_sticky (
    .clk          (clk),
    .hard_reset_n (hard_reset_n),
    .clr          (game_reset),
    .in           (player_hit),
    .tick         (frame_tick),
    .flag         (p_flag)
  );

  frame_sticky u_b_sticky (
    .clk          (clk),
    .hard_reset_n (hard_reset_n),
    .clr          (game_reset),
    .in           (boss_hit),
    .tick         (frame_tick),
    .flag         (b_flag)
  );

  // One extra bit keeps the compare exact so HP saturates at 0 instead of wrapping.
  always_comb begin
    dmg = ((b_flag && boss_vulnerable(game_state)) ? BULLET_W : '0)
        + ((game_state == ST_BOMB) ? BOMB_W : '0);
    if (dmg >= {1'b0, hp_q}) begin
      new_hp = '0;
    end else begin
      new_hp = hp_q - dmg[HP_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    coll_d  = 1'b0;
    die_d   = die_q;
    if (game_reset) begin
      state_d = J_IDLE;
      hp_d    = HP_INIT;
      die_d   = 1'b0;
    end else begin
      case (state_q)
        J_IDLE: begin
          if (game_en) state_d = J_ARMED;
        end
        J_ARMED: begin
          if (frame_tick) begin
            hp_d = new_hp;
            // A kill in the same frame as a player hit suppresses the life loss.
            coll_d = p_flag && (game_state == ST_PLAY) && (new_hp != '0);
            if (new_hp == '0) begin
              state_d = J_DEAD;
              die_d   = 1'b1;
            end else if (!game_en) begin
              state_d = J_IDLE;
            end
          end else if (!game_en) begin
            state_d = J_IDLE;
          end
        end
        J_DEAD: begin
          state_d = J_DEAD;
        end
        default: begin
          state_d = J_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_q <= J_IDLE;
      hp_q    <= HP_INIT;
      coll_q  <= 1'b0;
      die_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      coll_q  <= coll_d;
      die_q   <= die_d;
    end
  end

  assign collision = coll_q;
  assign die       = die_q;
  assign boss_hp   = hp_q;

endmodule
